pc_mt: RTL and testbench
========================

// Module: pc_mt
// PURPOSE
//  Multi-thread program counter for the fetch stage. Holds one PC per hardware
//  thread and interleaves fetch round-robin across non-halted threads. Supports
//  sequential, branch, jump and jump-register updates.
//  Sits between control/datapath muxes and the instruction memory address port.
//  Parametrised successor of the single-thread PC: it adds thread count,
//  per-thread reset vectors and per-thread halt.
// PARAMETERS
//  NTHREADS      2             number of hardware threads (>=1)
//  TID_W         $clog2(NTHREADS) (min 1) thread-id width
//  PC_INIT       32'h0000_0000 reset PC of thread 0
//  THREAD_STRIDE 32'h0000_0400 reset PC of thread t = PC_INIT + t*THREAD_STRIDE
// PORTS
//  CLK            in   1         clock, all state updates on rising edge
//  RST            in   1         synchronous active-high reset
//  pc_wait        in   1         stall: no PC, thread or halt state changes
//  halt           in   1         fetched thread executes halt
//  PCSrc          in   2         0 NEXT, 1 BRANCH, 2 JUMP, 3 JR (pc_mux_input_selection)
//  load_imm       in   16        branch offset in words, signed
//  load_addr      in   26        jump target field
//  jr_addr        in   32        jump-register target
//  imemaddr       out  32        PC of fetch_tid
//  next_imemaddr  out  32        imemaddr + 4
//  fetch_tid      out  TID_W     thread currently fetching
//  halted         out  NTHREADS  per-thread halted flags
//  all_halted     out  1         &halted
// BEHAVIOUR
//  - Reset (RST=1 at an edge, priority over everything):
//    pc[t]=PC_INIT+t*THREAD_STRIDE, halted=0, fetch_tid=0.
//    Mid-operation reset discards all state.
//  - Combinational outputs: imemaddr=pc[fetch_tid], next_imemaddr=imemaddr+4.
//    Both are 32-bit with modulo-2^32 wrap, e.g. 32'hFFFF_FFFC+4 -> 0.
//  - Control inputs always refer to the instruction at fetch_tid this cycle.
//  - Advance cycle (pc_wait=0, RST=0, halted[fetch_tid]=0):
//    NEXT:   pc[fetch_tid] <= next_imemaddr
//    BRANCH: pc[fetch_tid] <= next_imemaddr + {{14{imm[15]}},imm,2'b00}
//    JUMP:   pc[fetch_tid] <= {next_imemaddr[31:28],load_addr,2'b00}
//    JR:     pc[fetch_tid] <= jr_addr (low 2 bits passed unchanged)
//    halt=1: PCSrc is ignored, pc[fetch_tid] holds, halted[fetch_tid] <= 1.
//    The PCs of other threads never change.
//  - Thread select after an advance cycle: fetch_tid <= first t with halted[t]=0,
//    scanning fetch_tid+1, +2, ... modulo NTHREADS. The scan uses halted values
//    updated this cycle. If no other thread is runnable and the current thread
//    is still runnable, fetch_tid holds. If every thread is halted, fetch_tid holds.
//  - Stall (pc_wait=1): all registers hold; halt and PCSrc are ignored.
//  - If halted[fetch_tid]=1 with pc_wait=0 (all_halted): state holds and
//    inputs are ignored.
//  - halted clears only on RST. NTHREADS=1 degenerates to a single-thread PC.
//  - Latency: a new PC is visible on imemaddr one cycle after the edge, and only
//    once that thread is selected again.
// TESTING
//  1 Reset, NTHREADS=2: imemaddr=0, fetch_tid=0. Next edge NEXT: fetch_tid=1,
//    imemaddr=0x400. Next: fetch_tid=0, imemaddr=0x4.
//  2 Thread 0 at 0x10, BRANCH imm=16'hFFFE -> pc[0]=0x0C. imm=16'h0003 from
//    0x10 -> 0x20. pc[1] is unchanged in both cases.
//  3 Thread 1 at 0xF000_0400, JUMP load_addr=26'h0000100 -> 0xF000_0400.
//    JR jr_addr=0x1234 -> pc[1]=0x1234.
//  4 pc_wait=1 for 3 cycles with halt=1, PCSrc=JUMP -> imemaddr, fetch_tid and
//    halted are unchanged.
//  5 Halt thread 0 -> halted=2'b01. Fetch stays on thread 1 every cycle. Halt
//    thread 1 -> all_halted=1 and PCs freeze. Assert RST -> state returns to
//    the reset values.
//  6 Wrap: pc=0xFFFF_FFFC with NEXT -> 0x0000_0000. RST asserted together with
//    halt -> reset wins and halted=0.

Source files
------------

// File: rtl/pc_mt_if.sv
// Fetch-side bus of the multi-thread PC.
//   master : control/datapath side. It drives the stall, halt, PC-source select and
//            target fields, and it observes the fetch address, thread id and halt flags.
//   slave  : the pc_mt block itself.
// Signals:
//   pc_wait       stall; nothing changes while high
//   halt          the thread being fetched executes a halt
//   PCSrc         0 NEXT, 1 BRANCH, 2 JUMP, 3 JR
//   load_imm      signed branch offset, counted in words
//   load_addr     26-bit jump target field
//   jr_addr       jump-register target
//   imemaddr      PC of fetch_tid
//   next_imemaddr imemaddr + 4
//   fetch_tid     thread currently fetching
//   halted        per-thread halted flags
//   all_halted    every thread halted
interface pc_mt_if #(
  parameter int NTHREADS = 2,
  parameter int TID_W    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
);
  logic                pc_wait;
  logic                halt;
  logic [1:0]          PCSrc;
  logic [15:0]         load_imm;
  logic [25:0]         load_addr;
  logic [31:0]         jr_addr;
  logic [31:0]         imemaddr;
  logic [31:0]         next_imemaddr;
  logic [TID_W-1:0]    fetch_tid;
  logic [NTHREADS-1:0] halted;
  logic                all_halted;

  modport master (
    output pc_wait, halt, PCSrc, load_imm, load_addr, jr_addr,
    input  imemaddr, next_imemaddr, fetch_tid, halted, all_halted
  );

  modport slave (
    input  pc_wait, halt, PCSrc, load_imm, load_addr, jr_addr,
    output imemaddr, next_imemaddr, fetch_tid, halted, all_halted
  );
endinterface

// File: rtl/pc_mt.sv
// Multi-thread program counter for the fetch stage.
// The block holds one PC per hardware thread and interleaves fetch round-robin
// across the threads that are not halted.
// Ports:
//   CLK  clock; all state updates on the rising edge
//   RST  synchronous active-high reset; it has priority over everything
//   bus  pc_mt_if.slave, which carries the control inputs and the fetch address, thread id and halt outputs
// Reset vectors: pc[t] = PC_INIT + t*THREAD_STRIDE.
module pc_mt #(
  parameter int          NTHREADS      = 2,
  parameter int          TID_W         = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
  parameter logic [31:0] PC_INIT       = 32'h0000_0000,
  parameter logic [31:0] THREAD_STRIDE = 32'h0000_0400
) (
  input  logic   CLK,
  input  logic   RST,
  pc_mt_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_NEXT   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_JR     = 2'd3
  } pc_src_e;

  logic [NTHREADS-1:0][31:0] pc;
  logic [NTHREADS-1:0]       halted;
  logic [TID_W-1:0]          fetch_tid;

  logic [31:0]         cur_pc, seq_pc, pc_new;
  logic                advance;
  logic [NTHREADS-1:0] halted_nxt;
  logic [TID_W-1:0]    tid_nxt;
  logic                found;
  int                  idx;

  assign cur_pc = pc[fetch_tid];
  assign seq_pc = cur_pc + 32'd4;

  assign bus.imemaddr      = cur_pc;
  assign bus.next_imemaddr = seq_pc;
  assign bus.fetch_tid     = fetch_tid;
  assign bus.halted        = halted;
  assign bus.all_halted    = &halted;

  // A halted current thread only happens when every thread is halted,
  // so that case freezes the whole block.
  assign advance = !bus.pc_wait && !halted[fetch_tid];

  always_comb begin
    pc_new = seq_pc;
    case (pc_src_e'(bus.PCSrc))
      SRC_NEXT:   pc_new = seq_pc;
      SRC_BRANCH: pc_new = seq_pc + {{14{bus.load_imm[15]}}, bus.load_imm, 2'b00};
      SRC_JUMP:   pc_new = {seq_pc[31:28], bus.load_addr, 2'b00};
      SRC_JR:     pc_new = bus.jr_addr;
      default:    pc_new = seq_pc;
    endcase
  end

  always_comb begin
    halted_nxt = halted;
    if (advance && bus.halt) halted_nxt[fetch_tid] = 1'b1;
  end

  // The round-robin scan starts at fetch_tid+1. The last probe (k == NTHREADS)
  // lands back on the current thread, so fetch_tid holds when that thread is the only
  // runnable one. When every thread is halted, nothing is found and fetch_tid also holds.
  always_comb begin
    tid_nxt = fetch_tid;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NTHREADS; k++) begin
      idx = (int'(fetch_tid) + k) % NTHREADS;
      if (!found && !halted_nxt[idx[TID_W-1:0]]) begin
        tid_nxt = idx[TID_W-1:0];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int t = 0; t < NTHREADS; t++)
        pc[t] <= PC_INIT + 32'(t) * THREAD_STRIDE;
      halted    <= '0;
      fetch_tid <= '0;
    end else if (advance) begin
      if (!bus.halt) pc[fetch_tid] <= pc_new;
      halted    <= halted_nxt;
      fetch_tid <= tid_nxt;
    end
  end

endmodule

// File: tb/tb_pc_mt.sv
module tb_pc_mt;
  localparam int NT = 2;
  localparam int TW = 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pc_mt_if #(.NTHREADS(NT), .TID_W(TW)) bus ();

  pc_mt #(.NTHREADS(NT), .TID_W(TW), .PC_INIT(32'h0), .THREAD_STRIDE(32'h400)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: one PC per thread, a halted set and a current thread.
  logic [31:0] m_pc [NT];
  logic [NT-1:0] m_h;
  int m_tid;
  bit m_ok = 1'b0;

  function automatic logic [31:0] target(input logic [31:0] p, input logic [1:0] s,
                                         input logic [15:0] imm, input logic [25:0] la,
                                         input logic [31:0] jr);
    logic [31:0] seq;
    seq = p + 32'd4;
    case (s)
      2'd0: return seq;
      2'd1: return seq + 32'(int'($signed(imm)) * 4);
      2'd2: return (seq & 32'hF000_0000) | (32'(la) * 32'd4);
      default: return jr;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      for (int t = 0; t < NT; t++) m_pc[t] = 32'(t) * 32'h400;
      m_h = '0; m_tid = 0; m_ok = 1'b1;
    end else if (m_ok && !bus.pc_wait && !m_h[m_tid]) begin
      if (bus.halt) m_h[m_tid] = 1'b1;
      else m_pc[m_tid] = target(m_pc[m_tid], bus.PCSrc, bus.load_imm, bus.load_addr, bus.jr_addr);
      for (int k = 1; k <= NT; k++) begin
        if (!m_h[(m_tid + k) % NT]) begin
          m_tid = (m_tid + k) % NT;
          break;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (m_ok) begin
      chk("m_imemaddr", bus.imemaddr, m_pc[m_tid]);
      chk("m_next_imemaddr", bus.next_imemaddr, m_pc[m_tid] + 32'd4);
      chk("m_fetch_tid", 32'(bus.fetch_tid), 32'(m_tid));
      chk("m_halted", 32'(bus.halted), 32'(m_h));
      chk("m_all_halted", 32'(bus.all_halted), 32'(&m_h));
    end
  end

  task automatic cyc(input logic w, input logic h, input logic [1:0] s,
                     input logic [15:0] imm, input logic [25:0] la,
                     input logic [31:0] jr, input logic r);
    bus.pc_wait = w; bus.halt = h; bus.PCSrc = s;
    bus.load_imm = imm; bus.load_addr = la; bus.jr_addr = jr; RST = r;
    @(posedge CLK); #1;
  endtask

  task automatic nxt();  cyc(0, 0, 2'd0, 16'h0, 26'h0, 32'h0, 0); endtask
  task automatic jr(input logic [31:0] a); cyc(0, 0, 2'd3, 16'h0, 26'h0, a, 0); endtask
  task automatic br(input logic [15:0] i); cyc(0, 0, 2'd1, i, 26'h0, 32'h0, 0); endtask

  task automatic at(input string nm, input logic [31:0] tid, input logic [31:0] pc);
    chk({nm, "_tid"}, 32'(bus.fetch_tid), tid);
    chk({nm, "_pc"}, bus.imemaddr, pc);
  endtask

  initial begin
    cyc(0, 0, 2'd0, 16'h0, 26'h0, 32'h0, 1);
    cyc(0, 0, 2'd0, 16'h0, 26'h0, 32'h0, 1);
    // Reset values followed by round-robin fetch
    at("rst", 0, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    nxt(); at("t1a", 1, 32'h400);
    nxt(); at("t1b", 0, 32'h4);
    // Branches backward and forward from 0x10
    jr(32'h10);         at("t2a", 1, 32'h404);
    nxt();              at("t2b", 0, 32'h10);
    br(16'hFFFE);       at("t2c", 1, 32'h408);
    nxt();              at("t2d", 0, 32'h0C);
    jr(32'h10);         at("t2e", 1, 32'h40C);
    nxt();              at("t2f", 0, 32'h10);
    br(16'h0003);       at("t2g", 1, 32'h410);
    nxt();              at("t2h", 0, 32'h20);
    // JUMP keeps the top nibble of pc+4, then JR
    nxt();              at("t3a", 1, 32'h414);
    jr(32'hF000_0400);  at("t3b", 0, 32'h24);
    nxt();              at("t3c", 1, 32'hF000_0400);
    cyc(0, 0, 2'd2, 16'h0, 26'h0000100, 32'h0, 0); at("t3d", 0, 32'h28);
    nxt();              at("t3e", 1, 32'hF000_0400);
    jr(32'h1234);       at("t3f", 0, 32'h2C);
    nxt();              at("t3g", 1, 32'h1234);
    // A stall ignores halt and PCSrc
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 2'd2, 16'h0, 26'h3FFFFFF, 32'h0, 0);
      at("t4", 1, 32'h1234);
      chk("t4_halted", 32'(bus.halted), 32'h0);
    end
    // Halting one thread, then both
    nxt();              at("t5a", 0, 32'h30);
    cyc(0, 1, 2'd3, 16'h0, 26'h0, 32'hDEAD, 0);
    at("t5b", 1, 32'h1238);
    chk("t5b_halted", 32'(bus.halted), 32'h1);
    nxt();              at("t5c", 1, 32'h123C);
    nxt();              at("t5d", 1, 32'h1240);
    cyc(0, 1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    at("t5e", 1, 32'h1240);
    chk("t5e_all", 32'(bus.all_halted), 32'h1);
    nxt();              at("t5f", 1, 32'h1240);
    jr(32'h0);          at("t5g", 1, 32'h1240);
    cyc(0, 0, 2'd0, 16'h0, 26'h0, 32'h0, 1);
    at("t5h", 0, 32'h0);
    chk("t5h_halted", 32'(bus.halted), 32'h0);
    // 32-bit wrap, and reset taking priority over halt
    jr(32'hFFFF_FFFC);  at("t6a", 1, 32'h400);
    nxt();              at("t6b", 0, 32'hFFFF_FFFC);
    chk("t6b_next", bus.next_imemaddr, 32'h0);
    nxt();              at("t6c", 1, 32'h404);
    nxt();              at("t6d", 0, 32'h0);
    cyc(0, 1, 2'd0, 16'h0, 26'h0, 32'h0, 1);
    at("t6e", 0, 32'h0);
    chk("t6e_halted", 32'(bus.halted), 32'h0);
    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(3) == 0), ($urandom_range(15) == 0), 2'($urandom_range(3)),
          16'($urandom), 26'($urandom), $urandom, ($urandom_range(63) == 0));
    end
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
